// File: rtl/jtag_dm_pkg.sv
// Shared types, constants and RV32 instruction encoders for the debug-module
// abstract-command path.
package jtag_dm_pkg;

    localparam logic [11:0] DATA_ADDR_DEFAULT = 12'h380;
    localparam int          CMD_WORDS_DEFAULT = 10;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_EXEC
    } state_e;

    // Access Register command field offsets
    localparam int CMDTYPE_LSB  = 24;
    localparam int AARSIZE_LSB  = 20;
    localparam int POSTINC_BIT  = 19;
    localparam int POSTEXEC_BIT = 18;
    localparam int TRANSFER_BIT = 17;
    localparam int WRITE_BIT    = 16;
    localparam int REGNO_LSB    = 0;

    localparam logic [2:0]  AARSIZE_32 = 3'd2;
    localparam logic [15:0] GPR_FIRST  = 16'h1000;
    localparam logic [15:0] GPR_LAST   = 16'h101F;

    // lw rd, imm(x0)
    function automatic logic [31:0] rv_lw(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b010, rd, 7'b000_0011};
    endfunction

    // sw rs2, imm(x0)
    function automatic logic [31:0] rv_sw(input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, 5'd0, 3'b010, imm[4:0], 7'b010_0011};
    endfunction

endpackage

// File: rtl/jtag_cmd_gen.sv
// Combinational Access Register decoder: classifies the command and produces
// the two non-trivial buffer words (word0 transfer, word9 tail).
module jtag_cmd_gen
    import jtag_dm_pkg::*;
#(
    parameter logic [11:0] DATA_ADDR = DATA_ADDR_DEFAULT
) (
    input  logic [31:0] cmd,
    input  logic        halted,
    output cmderr_e     err,
    output logic [31:0] word0,
    output logic [31:0] word9
);

    logic [7:0]  cmdtype;
    logic [2:0]  aarsize;
    logic        postinc;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
    logic        unused_rsvd;

    assign cmdtype     = cmd[CMDTYPE_LSB +: 8];
    assign aarsize     = cmd[AARSIZE_LSB +: 3];
    assign postinc     = cmd[POSTINC_BIT];
    assign postexec    = cmd[POSTEXEC_BIT];
    assign transfer    = cmd[TRANSFER_BIT];
    assign write       = cmd[WRITE_BIT];
    assign regno       = cmd[REGNO_LSB +: 16];
    assign unused_rsvd = cmd[23];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        err = CMDERR_NONE;
        if (!halted) begin
            err = CMDERR_HALTRESUME;
        end else if (cmdtype != 8'd0 || postinc) begin
            err = CMDERR_NOTSUP;
        end else if (transfer && (aarsize != AARSIZE_32 || regno < GPR_FIRST || regno > GPR_LAST)) begin
            err = CMDERR_NOTSUP;
        end
    end

    // "write" moves data0 into the GPR (load); a read stores the GPR into data0.
    assign word0 = !transfer ? NOP
                 : write     ? rv_lw(regno[4:0], DATA_ADDR)
                 :             rv_sw(regno[4:0], DATA_ADDR);

    // With postexec the hart falls through into the program buffer instead of trapping.
    assign word9 = postexec ? NOP : EBREAK;

endmodule

// File: rtl/jtag_cmd_ctrl.sv
// Abstract-command sequencer: validates commands, holds the command buffer,
// drives the go flag and owns cmdbusy/cmderror.
module jtag_cmd_ctrl
    import jtag_dm_pkg::*;
#(
    parameter logic [11:0] DATA_ADDR = DATA_ADDR_DEFAULT,
    parameter int          CMD_WORDS = CMD_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic [2:0]  clear_cmderror_i,
    input  logic        halted_i,
    input  logic        going_i,
    input  logic        halted_wr_i,
    input  logic        exception_i,
    output logic        go_o,
    output logic        cmdbusy_o,
    output logic [2:0]  cmderror_o,
    input  logic [3:0]  buf_idx_i,
    output logic [31:0] buf_rdata_o
);

    state_e      state_q, state_d;
    cmderr_e     err_q, err_d;
    cmderr_e     gen_err;
    logic        accept;
    logic [31:0] gen_word0, gen_word9;
    logic [31:0] word0_q, word9_q;

    jtag_cmd_gen #(
        .DATA_ADDR (DATA_ADDR)
    ) u_gen (
        .cmd    (cmd_i),
        .halted (halted_i),
        .err    (gen_err),
        .word0  (gen_word0),
        .word9  (gen_word9)
    );

    always_comb begin
        state_d = state_q;
        err_d   = cmderr_e'(err_q & ~clear_cmderror_i);
        accept  = 1'b0;

        // A busy error is raised before the state case so an exception can still override it.
        if (state_q != ST_IDLE && cmd_valid_i && err_q == CMDERR_NONE) begin
            err_d = CMDERR_BUSY;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && err_q == CMDERR_NONE) begin
                    if (gen_err != CMDERR_NONE) begin
                        err_d = gen_err;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_GO;
                    end
                end
            end
            ST_GO: begin
                if (going_i) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exception_i) begin
                    err_d   = CMDERR_EXCEPT;
                    state_d = ST_IDLE;
                end else if (halted_wr_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= CMDERR_NONE;
            word0_q <= NOP;
            word9_q <= NOP;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                word0_q <= gen_word0;
                word9_q <= gen_word9;
            end
        end
    end

    assign go_o       = (state_q == ST_GO);
    assign cmdbusy_o  = (state_q != ST_IDLE);
    assign cmderror_o = err_q;

    // Words 1..CMD_WORDS-2 and any out-of-range index are constant NOPs; only the ends are stored.
    always_comb begin
        buf_rdata_o = NOP;
        if (buf_idx_i == 4'd0) begin
            buf_rdata_o = word0_q;
        end else if (buf_idx_i == 4'(CMD_WORDS - 1)) begin
            buf_rdata_o = word9_q;
        end
    end

endmodule

// File: tb/tb_jtag_cmd_ctrl.sv
// Directed self-checking bench for jtag_cmd_ctrl with DATA_ADDR = 0x380.
module tb_jtag_cmd_ctrl;

    localparam logic [31:0] NOP_W    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_W = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic [31:0] cmd_i = '0;
    logic [2:0]  clear_cmderror_i = '0;
    logic        halted_i = 1'b1;
    logic        going_i = 1'b0;
    logic        halted_wr_i = 1'b0;
    logic        exception_i = 1'b0;
    logic        go_o;
    logic        cmdbusy_o;
    logic [2:0]  cmderror_o;
    logic [3:0]  buf_idx_i = '0;
    logic [31:0] buf_rdata_o;

    int checks = 0;
    int errors = 0;

    jtag_cmd_ctrl #(
        .DATA_ADDR (12'h380),
        .CMD_WORDS (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_i            (cmd_i),
        .clear_cmderror_i (clear_cmderror_i),
        .halted_i         (halted_i),
        .going_i          (going_i),
        .halted_wr_i      (halted_wr_i),
        .exception_i      (exception_i),
        .go_o             (go_o),
        .cmdbusy_o        (cmdbusy_o),
        .cmderror_o       (cmderror_o),
        .buf_idx_i        (buf_idx_i),
        .buf_rdata_o      (buf_rdata_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        cmd_i       = c;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic pulse_going();
        going_i = 1'b1;
        tick();
        going_i = 1'b0;
    endtask

    task automatic pulse_halted_wr();
        halted_wr_i = 1'b1;
        tick();
        halted_wr_i = 1'b0;
    endtask

    task automatic pulse_exception();
        exception_i = 1'b1;
        tick();
        exception_i = 1'b0;
    endtask

    task automatic clear_all();
        clear_cmderror_i = 3'b111;
        tick();
        clear_cmderror_i = 3'b000;
    endtask

    task automatic read_word(input logic [3:0] idx, output logic [31:0] w);
        buf_idx_i = idx;
        #1;
        w = buf_rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] w;
        logic [3:0]  idx_tab [4];
        idx_tab = '{4'd0, 4'd5, 4'd9, 4'd12};
        rst = 1'b1;
        tick();
        checks++;
        if (go_o !== 1'b0 || cmdbusy_o !== 1'b0 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: go=%b busy=%b err=%0d, want 0/0/0", go_o, cmdbusy_o, cmderror_o);
        end
        foreach (idx_tab[i]) begin
            read_word(idx_tab[i], w);
            checks++;
            if (w !== NOP_W) begin
                errors++;
                $display("FAIL reset_word%0d: got %h want %h", idx_tab[i], w, NOP_W);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_x8();
        logic [31:0] w;
        halted_i = 1'b1;
        send_cmd(32'h0022_1008);
        checks++;
        if (go_o !== 1'b1 || cmdbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL read_go_latency: go=%b busy=%b want 1/1", go_o, cmdbusy_o);
        end
        read_word(4'd0, w);
        checks++;
        if (w !== 32'h3880_2023) begin
            errors++;
            $display("FAIL read_word0: got %h want 38802023", w);
        end
        read_word(4'd9, w);
        checks++;
        if (w !== EBREAK_W) begin
            errors++;
            $display("FAIL read_word9: got %h want %h", w, EBREAK_W);
        end
        read_word(4'd4, w);
        checks++;
        if (w !== NOP_W) begin
            errors++;
            $display("FAIL read_word4: got %h want %h", w, NOP_W);
        end
        tick();
        checks++;
        if (go_o !== 1'b1) begin
            errors++;
            $display("FAIL read_go_hold: go=%b want 1", go_o);
        end
        pulse_going();
        checks++;
        if (go_o !== 1'b0 || cmdbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL read_going: go=%b busy=%b want 0/1", go_o, cmdbusy_o);
        end
        pulse_halted_wr();
        checks++;
        if (cmdbusy_o !== 1'b0 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL read_done: busy=%b err=%0d want 0/0", cmdbusy_o, cmderror_o);
        end
    endtask

    task automatic test_write_and_postexec();
        logic [31:0] w;
        send_cmd(32'h0023_1008);
        read_word(4'd0, w);
        checks++;
        if (w !== 32'h3800_2403) begin
            errors++;
            $display("FAIL write_word0: got %h want 38002403", w);
        end
        pulse_going();
        pulse_halted_wr();
        send_cmd(32'h0024_1000);
        read_word(4'd0, w);
        checks++;
        if (w !== NOP_W) begin
            errors++;
            $display("FAIL postexec_word0: got %h want %h", w, NOP_W);
        end
        read_word(4'd9, w);
        checks++;
        if (w !== NOP_W) begin
            errors++;
            $display("FAIL postexec_word9: got %h want %h", w, NOP_W);
        end
        pulse_going();
        pulse_halted_wr();
        checks++;
        if (cmdbusy_o !== 1'b0 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL postexec_done: busy=%b err=%0d want 0/0", cmdbusy_o, cmderror_o);
        end
    endtask

    task automatic test_errors();
        logic [31:0] w;
        logic [31:0] bad_tab [5];
        bad_tab = '{32'h0033_1008,   // aarsize 3
                    32'h0122_1008,   // cmdtype 1
                    32'h002A_1008,   // aarpostincrement
                    32'h0022_1020,   // regno one past x31
                    32'h0022_0FFF};  // regno one below x0
        halted_i = 1'b0;
        send_cmd(32'h0022_1008);
        checks++;
        if (cmderror_o !== 3'd4 || go_o !== 1'b0 || cmdbusy_o !== 1'b0) begin
            errors++;
            $display("FAIL not_halted: err=%0d go=%b busy=%b want 4/0/0", cmderror_o, go_o, cmdbusy_o);
        end
        clear_all();
        halted_i = 1'b1;
        foreach (bad_tab[i]) begin
            send_cmd(bad_tab[i]);
            checks++;
            if (cmderror_o !== 3'd2 || cmdbusy_o !== 1'b0) begin
                errors++;
                $display("FAIL notsup_%h: err=%0d busy=%b want 2/0", bad_tab[i], cmderror_o, cmdbusy_o);
            end
            clear_all();
        end
        // Top of the GPR range is accepted.
        send_cmd(32'h0022_101F);
        read_word(4'd0, w);
        checks++;
        if (cmdbusy_o !== 1'b1 || w !== 32'h39F0_2023) begin
            errors++;
            $display("FAIL regno_x31: busy=%b word0=%h want 1/39f02023", cmdbusy_o, w);
        end
        pulse_going();
        pulse_halted_wr();
        // Busy error during EXEC leaves the in-flight command intact.
        send_cmd(32'h0022_1008);
        pulse_going();
        send_cmd(32'h0023_1009);
        checks++;
        if (cmderror_o !== 3'd1 || cmdbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_err: err=%0d busy=%b want 1/1", cmderror_o, cmdbusy_o);
        end
        pulse_halted_wr();
        read_word(4'd0, w);
        checks++;
        if (cmdbusy_o !== 1'b0 || cmderror_o !== 3'd1 || w !== 32'h3880_2023) begin
            errors++;
            $display("FAIL busy_inflight: busy=%b err=%0d word0=%h want 0/1/38802023", cmdbusy_o, cmderror_o, w);
        end
        clear_all();
    endtask

    task automatic test_exception();
        // Hart events outside their consuming state are ignored.
        exception_i = 1'b1;
        going_i     = 1'b1;
        halted_wr_i = 1'b1;
        tick();
        exception_i = 1'b0;
        going_i     = 1'b0;
        halted_wr_i = 1'b0;
        checks++;
        if (cmdbusy_o !== 1'b0 || go_o !== 1'b0 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b go=%b err=%0d want 0/0/0", cmdbusy_o, go_o, cmderror_o);
        end
        send_cmd(32'h0022_1008);
        pulse_exception();
        checks++;
        if (go_o !== 1'b1 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL go_ignore_exc: go=%b err=%0d want 1/0", go_o, cmderror_o);
        end
        pulse_going();
        exception_i = 1'b1;
        halted_wr_i = 1'b1;
        tick();
        exception_i = 1'b0;
        halted_wr_i = 1'b0;
        checks++;
        if (cmderror_o !== 3'd3 || cmdbusy_o !== 1'b0) begin
            errors++;
            $display("FAIL exc_wins: err=%0d busy=%b want 3/0", cmderror_o, cmdbusy_o);
        end
        send_cmd(32'h0022_1008);
        checks++;
        if (cmdbusy_o !== 1'b0 || go_o !== 1'b0 || cmderror_o !== 3'd3) begin
            errors++;
            $display("FAIL ignore_with_err: busy=%b go=%b err=%0d want 0/0/3", cmdbusy_o, go_o, cmderror_o);
        end
        clear_cmderror_i = 3'b001;
        tick();
        clear_cmderror_i = 3'b000;
        checks++;
        if (cmderror_o !== 3'd2) begin
            errors++;
            $display("FAIL partial_clear: err=%0d want 2", cmderror_o);
        end
        clear_all();
        checks++;
        if (cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL full_clear: err=%0d want 0", cmderror_o);
        end
    endtask

    task automatic test_set_over_clear();
        send_cmd(32'h0022_1008);
        clear_cmderror_i = 3'b111;
        send_cmd(32'h0023_1008);
        clear_cmderror_i = 3'b000;
        checks++;
        if (cmderror_o !== 3'd1 || go_o !== 1'b1) begin
            errors++;
            $display("FAIL set_over_clear: err=%0d go=%b want 1/1", cmderror_o, go_o);
        end
        pulse_going();
        pulse_halted_wr();
        clear_all();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0, w9;
        send_cmd(32'h0022_1008);
        checks++;
        if (go_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: go=%b want 1", go_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (go_o !== 1'b0 || cmdbusy_o !== 1'b0 || cmderror_o !== 3'd0) begin
            errors++;
            $display("FAIL rst_async: go=%b busy=%b err=%0d want 0/0/0", go_o, cmdbusy_o, cmderror_o);
        end
        read_word(4'd0, w0);
        read_word(4'd9, w9);
        checks++;
        if (w0 !== NOP_W || w9 !== NOP_W) begin
            errors++;
            $display("FAIL rst_words: word0=%h word9=%h want %h", w0, w9, NOP_W);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_x8();
        test_write_and_postexec();
        test_errors();
        test_exception();
        test_set_over_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
